pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle RISC-V core. It replaces the plain PC register. It adds a configurable reset vector, stall, taken-branch/jump redirect, trap entry, misaligned-target detection and a small circular return-address stack (RAS) for call/return prediction. It sits at the front of the datapath and drives instruction-memory address and PC+4 to the rest of the core.

Parameters:
XLEN, 32, PC/address width in bits (≥8)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect
RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall_i  input  1  hold PC and RAS this cycle
redirect_i  input  1  taken branch/jump; next PC = redirect_target_i
redirect_target_i  input  XLEN  branch/jump target
trap_i  input  1  exception/ecall; next PC = TRAP_VECTOR
call_i  input  1  current instruction is a call; push pc_plus4_o
ret_i  input  1  current instruction is a return; pop RAS for next PC
pc_o  output  XLEN  current PC
pc_plus4_o  output  XLEN  pc_o + 4, combinational, modulo 2^XLEN
misaligned_o  output  1  registered one-cycle pulse: last redirect target had bits[1:0]≠0
bad_addr_o  output  XLEN  captured misaligned target
ras_count_o  output  clog2(RAS_DEPTH)+1  valid RAS entries
ras_miss_o  output  1  registered one-cycle pulse: ret_i with empty RAS

Behaviour:
- Reset (async, any time): pc_o=RESET_VECTOR; misaligned_o=0; bad_addr_o=0; ras_count_o=0; ras_miss_o=0; RAS pointer=0; entry contents don't-care.
- All updates happen on the rising clk edge. Pulse outputs are 1 for exactly the cycle after the event, otherwise 0.
- Next-PC priority, highest first:
  1. trap_i → TRAP_VECTOR. Overrides stall_i.
  2. stall_i → hold pc_o. RAS unchanged. Pulses cleared.
  3. redirect_i with target[1:0]==0 → redirect_target_i.
  4. redirect_i with target[1:0]≠0 → TRAP_VECTOR; misaligned_o=1; bad_addr_o=target.
  5. ret_i with ras_count>0 → RAS top.
  6. ret_i with ras_count==0 → pc_plus4_o; ras_miss_o=1.
  7. Otherwise → pc_plus4_o. Wrap from all-ones−3 to 0 is allowed.
- RAS operations happen only when neither stall_i nor trap_i is active. They are independent of whether redirect_i wins the PC selection (call/ret are jumps that also assert redirect_i).
- Push (call_i only):
  - write pc_plus4_o at ptr, ptr+1 mod RAS_DEPTH.
  - count = min(count+1, RAS_DEPTH).
  - When full, the push overwrites the oldest entry and count stays at RAS_DEPTH.
- Pop (ret_i only, count>0): ptr−1 mod RAS_DEPTH, count−1. Pop when empty: no state change except ras_miss_o.
- call_i and ret_i together (co-routine swap):
  - next PC = top if count>0;
  - top entry is replaced by pc_plus4_o; count unchanged.
  - When empty, behaves as a push plus ras_miss_o.
- When ret_i and redirect_i are both set, redirect_i takes precedence for the PC. The RAS pop still occurs.
- trap_i leaves RAS contents and count intact.
- Reset asserted mid-operation clears all state immediately, with no dependence on clk.

Test Plan:
- Reset release, no controls → pc_o 0x0,0x4,0x8,0xC on successive edges; pc_plus4_o=pc_o+4.
- stall_i high 3 cycles at PC=0x8 → pc_o stays 0x8, then 0xC after release. trap_i during a stall → pc_o=0x100 next edge.
- redirect_i=1, target=0x40 → pc_o=0x40. Target=0x42 → pc_o=0x100, misaligned_o=1 for one cycle, bad_addr_o=0x42.
- Calls at PC 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4, 5 pushes) → count saturates at 4. Four rets yield 0x54, 0x44, 0x34, 0x24. Fifth ret gives ras_miss_o=1 and pc_o=previous+4.
- call_i and ret_i together with top=0x24 at PC=0x80 → pc_o=0x24, top now 0x84, count unchanged.
- Assert reset asynchronously mid-cycle with count=3, PC=0x200 → pc_o=RESET_VECTOR and ras_count_o=0 before the next clk edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: reset/trap vectors, stall, redirect with misalignment
// detection, and a circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int unsigned           XLEN         = 32,
  parameter logic [XLEN-1:0]       RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned           RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_i,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_target_i,
  input  logic                         trap_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  output logic [XLEN-1:0]              pc_o,
  output logic [XLEN-1:0]              pc_plus4_o,
  output logic                         misaligned_o,
  output logic [XLEN-1:0]              bad_addr_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_miss_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;
  logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
  logic             ras_miss_q, ras_miss_d;

  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic [PTR_W-1:0] top_idx;
  logic             ras_active;
  logic             ras_empty;
  logic             ras_full;
  logic             target_misaligned;

  assign pc_plus4_o        = pc_q + XLEN'(4);
  assign top_idx           = ptr_q - PTR_W'(1);
  assign ras_active        = !trap_i && !stall_i;
  assign ras_empty         = (count_q == '0);
  assign ras_full          = (count_q == CNT_W'(RAS_DEPTH));
  assign target_misaligned = (redirect_target_i[1:0] != 2'b00);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    pc_d         = pc_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    misaligned_d = 1'b0;
    bad_addr_d   = bad_addr_q;
    ras_miss_d   = 1'b0;
    ras_we       = 1'b0;
    ras_waddr    = ptr_q;

    // Stack bookkeeping is independent of which source wins the PC mux.
    if (ras_active) begin
      if (call_i && ret_i) begin
        if (ras_empty) begin
          ras_we     = 1'b1;
          ras_waddr  = ptr_q;
          ptr_d      = ptr_q + PTR_W'(1);
          count_d    = count_q + CNT_W'(1);
          ras_miss_d = 1'b1;
        end else begin
          ras_we    = 1'b1;
          ras_waddr = top_idx;
        end
      end else if (call_i) begin
        ras_we    = 1'b1;
        ras_waddr = ptr_q;
        ptr_d     = ptr_q + PTR_W'(1);
        if (!ras_full) count_d = count_q + CNT_W'(1);
      end else if (ret_i) begin
        if (ras_empty) begin
          ras_miss_d = 1'b1;
        end else begin
          ptr_d   = top_idx;
          count_d = count_q - CNT_W'(1);
        end
      end
    end

    if (trap_i) begin
      pc_d = TRAP_VECTOR;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (redirect_i) begin
      if (target_misaligned) begin
        pc_d         = TRAP_VECTOR;
        misaligned_d = 1'b1;
        bad_addr_d   = redirect_target_i;
      end else begin
        pc_d = redirect_target_i;
      end
    end else if (ret_i && !ras_empty) begin
      pc_d = ras_q[top_idx];
    end else begin
      pc_d = pc_plus4_o;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      ptr_q        <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
      bad_addr_q   <= '0;
      ras_miss_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      bad_addr_q   <= bad_addr_d;
      ras_miss_q   <= ras_miss_d;
    end
  end

  // NOTE: stack entries are deliberately not reset; the count says which are
  // valid, and leaving them out of reset lets the array map onto plain storage.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_waddr] <= pc_plus4_o;
  end

  assign pc_o         = pc_q;
  assign misaligned_o = misaligned_q;
  assign bad_addr_o   = bad_addr_q;
  assign ras_count_o  = count_q;
  assign ras_miss_o   = ras_miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expected values.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redirect_i, trap_i, call_i, ret_i;
  logic [31:0] redirect_target_i;
  logic [31:0] pc_o, pc_plus4_o, bad_addr_o;
  logic        misaligned_o, ras_miss_o;
  logic [2:0]  ras_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .trap_i            (trap_i),
    .call_i            (call_i),
    .ret_i             (ret_i),
    .pc_o              (pc_o),
    .pc_plus4_o        (pc_plus4_o),
    .misaligned_o      (misaligned_o),
    .bad_addr_o        (bad_addr_o),
    .ras_count_o       (ras_count_o),
    .ras_miss_o        (ras_miss_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; redirect_i = 0; trap_i = 0; call_i = 0; ret_i = 0;
    redirect_target_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one control set for one edge, then release all controls.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt,
                     input logic tr, input logic ca, input logic re);
    stall_i = st; redirect_i = rd; redirect_target_i = tgt;
    trap_i = tr; call_i = ca; ret_i = re;
    step();
    idle();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_o, 32'h0);
    check("rst_cnt", 32'(ras_count_o), 32'd0);
    check("rst_mis", 32'(misaligned_o), 32'd0);
    check("rst_bad", bad_addr_o, 32'h0);
    check("rst_miss", 32'(ras_miss_o), 32'd0);
    reset = 1'b0;
    check("pc0", pc_o, 32'h0);
    check("pc0_p4", pc_plus4_o, 32'h4);

    step(); check("pc4", pc_o, 32'h4);
    step(); check("pc8", pc_o, 32'h8);
    check("pc8_p4", pc_plus4_o, 32'hC);

    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", pc_o, 32'h8);
    end
    stall_i = 0;
    step(); check("stall_rel", pc_o, 32'hC);

    cyc(1, 0, 0, 1, 0, 0); check("trap_in_stall", pc_o, 32'h100);

    cyc(0, 1, 32'h40, 0, 0, 0); check("redir_ok", pc_o, 32'h40);
    check("redir_ok_mis", 32'(misaligned_o), 32'd0);
    cyc(0, 1, 32'h42, 0, 0, 0); check("redir_mis_pc", pc_o, 32'h100);
    check("redir_mis_flag", 32'(misaligned_o), 32'd1);
    check("redir_bad", bad_addr_o, 32'h42);
    step(); check("mis_pulse_end", 32'(misaligned_o), 32'd0);
    check("bad_held", bad_addr_o, 32'h42);
    check("pc_after_mis", pc_o, 32'h104);

    // Five calls at 0x10..0x50; the fifth overwrites the oldest entry.
    cyc(0, 1, 32'h10, 0, 0, 0); check("goto10", pc_o, 32'h10);
    cyc(0, 1, 32'h20, 0, 1, 0); check("call1_cnt", 32'(ras_count_o), 32'd1);
    cyc(0, 1, 32'h30, 0, 1, 0); check("call2_cnt", 32'(ras_count_o), 32'd2);
    cyc(0, 1, 32'h40, 0, 1, 0); check("call3_cnt", 32'(ras_count_o), 32'd3);
    cyc(0, 1, 32'h50, 0, 1, 0); check("call4_cnt", 32'(ras_count_o), 32'd4);
    cyc(0, 1, 32'h60, 0, 1, 0); check("call5_sat", 32'(ras_count_o), 32'd4);
    check("call5_pc", pc_o, 32'h60);

    cyc(0, 0, 0, 0, 0, 1); check("ret1", pc_o, 32'h54);
    check("ret1_cnt", 32'(ras_count_o), 32'd3);
    cyc(0, 0, 0, 0, 0, 1); check("ret2", pc_o, 32'h44);
    cyc(0, 0, 0, 0, 0, 1); check("ret3", pc_o, 32'h34);
    cyc(0, 0, 0, 0, 0, 1); check("ret4", pc_o, 32'h24);
    check("ret4_cnt", 32'(ras_count_o), 32'd0);
    check("ret4_nomiss", 32'(ras_miss_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 1); check("ret5_pc", pc_o, 32'h28);
    check("ret5_miss", 32'(ras_miss_o), 32'd1);
    check("ret5_cnt", 32'(ras_count_o), 32'd0);
    step(); check("miss_pulse_end", 32'(ras_miss_o), 32'd0);
    check("pc_2c", pc_o, 32'h2C);

    // Co-routine swap with top=0x24 at PC=0x80.
    cyc(0, 1, 32'h20, 0, 0, 0);
    cyc(0, 1, 32'h80, 0, 1, 0); check("setup_cnt", 32'(ras_count_o), 32'd1);
    check("setup_pc", pc_o, 32'h80);
    cyc(0, 0, 0, 0, 1, 1); check("swap_pc", pc_o, 32'h24);
    check("swap_cnt", 32'(ras_count_o), 32'd1);
    check("swap_nomiss", 32'(ras_miss_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 1); check("swap_top", pc_o, 32'h84);
    check("swap_pop_cnt", 32'(ras_count_o), 32'd0);

    // Swap on an empty stack acts as a push plus a miss.
    cyc(0, 0, 0, 0, 1, 1); check("eswap_pc", pc_o, 32'h88);
    check("eswap_miss", 32'(ras_miss_o), 32'd1);
    check("eswap_cnt", 32'(ras_count_o), 32'd1);
    cyc(0, 0, 0, 0, 0, 1); check("eswap_pop", pc_o, 32'h88);

    // ret together with redirect: redirect wins the PC, pop still happens.
    cyc(0, 0, 0, 0, 1, 0); check("call_plain", pc_o, 32'h8C);
    check("call_plain_cnt", 32'(ras_count_o), 32'd1);
    cyc(0, 1, 32'h300, 0, 0, 1); check("retredir_pc", pc_o, 32'h300);
    check("retredir_cnt", 32'(ras_count_o), 32'd0);

    // Trap leaves the stack alone, and a stalled call does not push.
    cyc(0, 0, 0, 0, 1, 0); check("call304", 32'(ras_count_o), 32'd1);
    cyc(0, 0, 0, 1, 1, 0); check("trap_pc", pc_o, 32'h100);
    check("trap_cnt", 32'(ras_count_o), 32'd1);
    cyc(1, 0, 0, 0, 1, 0); check("stall_call_cnt", 32'(ras_count_o), 32'd1);
    cyc(0, 0, 0, 0, 0, 1); check("ret_after_trap", pc_o, 32'h304);

    // Wrap from all-ones minus 3 to zero.
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0); check("wrap_p4", pc_plus4_o, 32'h0);
    step(); check("wrap_pc", pc_o, 32'h0);

    // Asynchronous reset mid-cycle with count=3, PC=0x200.
    cyc(0, 1, 32'h1F4, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("pre_arst_pc", pc_o, 32'h200);
    check("pre_arst_cnt", 32'(ras_count_o), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_cnt", 32'(ras_count_o), 32'd0);
    #1 reset = 1'b0;
    step(); check("post_arst_pc", pc_o, 32'h4);
    check("post_arst_cnt", 32'(ras_count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
